// File: rtl/dispatch_pkg.sv
// Shared types and sizing for the vending dispatch arbiter.
package dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    DISPENSE = 2'b01,
    ACK      = 2'b10,
    RELEASE  = 2'b11
  } state_e;

  localparam int unsigned DISPENSE_CYCLES_DEFAULT = 4;
  localparam int unsigned TIMER_W                 = 4;
  localparam int unsigned SALES_W                 = 8;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant with a 1-bit last-grant pointer (bit 0 = A, bit 1 = B).
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req_vld,
  output logic [1:0] gnt
);

  logic last_b_q;
  logic last_b_d;

  always_comb begin
    gnt      = 2'b00;
    last_b_d = last_b_q;
    if (en) begin
      if (req_vld == 2'b11) begin
        gnt = last_b_q ? 2'b01 : 2'b10;
      end else begin
        gnt = req_vld;
      end
      if (gnt[1]) begin
        last_b_d = 1'b1;
      end else if (gnt[0]) begin
        last_b_d = 1'b0;
      end
    end
  end

  // Pointer resets to "B granted last" so A wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end

endmodule

// File: rtl/dispatch_arbiter.sv
// Dispatch FSM for a two-product vending machine; SALES_COUNT_EN adds a saturating sale counter.
module dispatch_arbiter
  import dispatch_pkg::*;
#(
  parameter int unsigned DISPENSE_CYCLES = DISPENSE_CYCLES_DEFAULT
) (
  input  logic               clk1,
  input  logic               reset1,
  input  logic               reqA,
  input  logic               reqB,
  input  logic               stockA,
  input  logic               stockB,
  output logic               redInventarioA,
  output logic               redInventarioB,
  output logic               motorOn,
  output logic               busy,
  output logic               ackA,
  output logic               ackB,
`ifdef SALES_COUNT_EN
  output logic [SALES_W-1:0] salesCount,
`endif
  output logic               reject
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DISPENSE_CYCLES - 1);

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 sel_b_q, sel_b_d;
  logic                 red_a_q, red_a_d, red_b_q, red_b_d;
  logic                 ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic                 motor_q, motor_d, busy_q, busy_d;
  logic                 reject_q, reject_d;
  logic [1:0]           gnt;

  rr_arbiter2 u_rr (
    .clk     (clk1),
    .rst_n   (reset1),
    .en      (state_q == IDLE),
    .req_vld ({reqB & stockB, reqA & stockA}),
    .gnt     (gnt)
  );

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    sel_b_d  = sel_b_q;
    red_a_d  = 1'b0;
    red_b_d  = 1'b0;
    ack_a_d  = 1'b0;
    ack_b_d  = 1'b0;
    reject_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          state_d = DISPENSE;
          timer_d = '0;
          sel_b_d = gnt[1];
          red_a_d = gnt[0];
          red_b_d = gnt[1];
        end else if ((reqA & ~stockA) | (reqB & ~stockB)) begin
          // Alternate so a persistent empty request pulses every other cycle.
          reject_d = ~reject_q;
        end
      end
      DISPENSE: begin
        if (timer_q == TIMER_LAST) begin
          state_d = ACK;
          ack_a_d = ~sel_b_q;
          ack_b_d = sel_b_q;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ACK: state_d = RELEASE;
      RELEASE: begin
        if (!(sel_b_q ? reqB : reqA)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    motor_d = (state_d == DISPENSE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk1) begin
    if (!reset1) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      sel_b_q  <= 1'b0;
      red_a_q  <= 1'b0;
      red_b_q  <= 1'b0;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      motor_q  <= 1'b0;
      busy_q   <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      sel_b_q  <= sel_b_d;
      red_a_q  <= red_a_d;
      red_b_q  <= red_b_d;
      ack_a_q  <= ack_a_d;
      ack_b_q  <= ack_b_d;
      motor_q  <= motor_d;
      busy_q   <= busy_d;
      reject_q <= reject_d;
    end
  end

`ifdef SALES_COUNT_EN
  logic [SALES_W-1:0] sales_q, sales_d;

  always_comb begin
    sales_d = sales_q;
    if ((ack_a_q | ack_b_q) && (sales_q != '1)) begin
      sales_d = sales_q + SALES_W'(1);
    end
  end

  always_ff @(posedge clk1) begin
    if (!reset1) begin
      sales_q <= '0;
    end else begin
      sales_q <= sales_d;
    end
  end

  assign salesCount = sales_q;
`endif

  assign redInventarioA = red_a_q;
  assign redInventarioB = red_b_q;
  assign motorOn        = motor_q;
  assign busy           = busy_q;
  assign ackA           = ack_a_q;
  assign ackB           = ack_b_q;
  assign reject         = reject_q;

endmodule

// File: tb/tb_dispatch_arbiter.sv
// Directed and random checks of dispatch_arbiter against a sale-age reference model.
module tb_dispatch_arbiter;

  localparam int D = 4;

  logic clk1 = 1'b0;
  logic reset1, reqA, reqB, stockA, stockB;
  logic redInventarioA, redInventarioB, motorOn, busy, ackA, ackB, reject;
`ifdef SALES_COUNT_EN
  logic [7:0] salesCount;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Model: age 0 = idle, 1..D = dispensing, D+1 = ack cycle, D+2 = waiting for release.
  int m_age  = 0;
  int m_prod = 0;
  int m_last = 1;
  int m_rej  = 0;
  int m_cnt  = 0;

  always #5 clk1 = ~clk1;

  dispatch_arbiter #(.DISPENSE_CYCLES(D)) dut (
    .clk1           (clk1),
    .reset1         (reset1),
    .reqA           (reqA),
    .reqB           (reqB),
    .stockA         (stockA),
    .stockB         (stockB),
    .redInventarioA (redInventarioA),
    .redInventarioB (redInventarioB),
    .motorOn        (motorOn),
    .busy           (busy),
    .ackA           (ackA),
    .ackB           (ackB),
`ifdef SALES_COUNT_EN
    .salesCount     (salesCount),
`endif
    .reject         (reject)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int va, vb;
    if (!reset1) begin
      m_age = 0; m_last = 1; m_rej = 0; m_cnt = 0;
      return;
    end
    if (m_age == D + 1 && m_cnt < 255) m_cnt++;
    if (m_age == 0) begin
      va = int'(reqA & stockA);
      vb = int'(reqB & stockB);
      if (va + vb > 0) begin
        m_prod = (va + vb == 2) ? 1 - m_last : vb;
        m_last = m_prod;
        m_age  = 1;
        m_rej  = 0;
      end else if ((reqA && !stockA) || (reqB && !stockB)) begin
        m_rej = 1 - m_rej;
      end else begin
        m_rej = 0;
      end
    end else if (m_age <= D + 1) begin
      m_age++;
    end else if (!(m_prod == 1 ? reqB : reqA)) begin
      m_age = 0;
    end
  endtask

  task automatic step();
    @(posedge clk1);
    model_edge();
    #1;
    chk("redA",   {7'd0, redInventarioA}, (m_age == 1 && m_prod == 0) ? 8'd1 : 8'd0);
    chk("redB",   {7'd0, redInventarioB}, (m_age == 1 && m_prod == 1) ? 8'd1 : 8'd0);
    chk("motor",  {7'd0, motorOn}, (m_age >= 1 && m_age <= D) ? 8'd1 : 8'd0);
    chk("busy",   {7'd0, busy}, (m_age != 0) ? 8'd1 : 8'd0);
    chk("ackA",   {7'd0, ackA}, (m_age == D + 1 && m_prod == 0) ? 8'd1 : 8'd0);
    chk("ackB",   {7'd0, ackB}, (m_age == D + 1 && m_prod == 1) ? 8'd1 : 8'd0);
    chk("reject", {7'd0, reject}, 8'(m_rej));
`ifdef SALES_COUNT_EN
    chk("sales",  salesCount, 8'(m_cnt));
`endif
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int n_red, n_ack;
    logic [1:0] tie_exp;

    reset1 = 1'b0; reqA = 1'b0; reqB = 1'b0; stockA = 1'b1; stockB = 1'b1;
    run(2);
    chk("reset_busy", {7'd0, busy}, 8'd0);
    reset1 = 1'b1;
    run(2);

    // Single sale of A
    reqA = 1'b1;
    step();
    chk("single_red", {7'd0, redInventarioA}, 8'd1);
    run(D);
    chk("single_ack", {7'd0, ackA}, 8'd1);
    run(3);
    reqA = 1'b0;
    run(2);
    chk("single_idle", {7'd0, busy}, 8'd0);

    // Ties after reset: A, then B, then A
    reset1 = 1'b0; run(1); reset1 = 1'b1;
    tie_exp = 2'b00;
    for (int t = 0; t < 3; t++) begin
      reqA = 1'b1; reqB = 1'b1;
      step();
      tie_exp[0] = (t == 1);
      chk("tie_grantB", {7'd0, redInventarioB}, {7'd0, tie_exp[0]});
      run(D + 2);
      reqA = 1'b0; reqB = 1'b0;
      run(2);
    end

    // Empty product B requested
    stockB = 1'b0; reqB = 1'b1;
    run(8);
    reqB = 1'b0;
    run(2);

    // Mixed: A empty, both requested -> B
    stockA = 1'b0; stockB = 1'b1; reqA = 1'b1; reqB = 1'b1;
    step();
    chk("mixed_grantB", {7'd0, redInventarioB}, 8'd1);
    run(D + 2);
    reqA = 1'b0; reqB = 1'b0; stockA = 1'b1;
    run(2);

    // Held button for 20 cycles
    n_red = 0; n_ack = 0;
    reqA = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      n_red += int'(redInventarioA);
      n_ack += int'(ackA);
    end
    chk("held_red_count", 8'(n_red), 8'd1);
    chk("held_ack_count", 8'(n_ack), 8'd1);
    reqA = 1'b0;
    run(2);

    // Reset in the second DISPENSE cycle aborts the sale
    reqA = 1'b1;
    run(2);
    reset1 = 1'b0;
    step();
    chk("abort_motor", {7'd0, motorOn}, 8'd0);
    reset1 = 1'b1; reqA = 1'b0;
    n_ack = 0;
    for (int i = 0; i < D + 3; i++) begin
      step();
      n_ack += int'(ackA);
    end
    chk("abort_no_ack", 8'(n_ack), 8'd0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset1 = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 3) == 0) reqA = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 3) == 0) reqB = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 7) == 0) stockA = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 7) == 0) stockB = $urandom_range(0, 3) != 0;
      step();
    end

`ifdef SALES_COUNT_EN
    reset1 = 1'b0; reqA = 1'b0; reqB = 1'b0; stockA = 1'b1; stockB = 1'b1;
    run(1);
    reset1 = 1'b1;
    for (int s = 0; s < 300; s++) begin
      reqA = 1'b1;
      run(D + 2);
      reqA = 1'b0;
      run(2);
    end
    chk("sales_saturate", salesCount, 8'd255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
